// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
// Issue/sequencing controller for the HI/LO multiply-divide datapath. It sits
// between the E stage and the datapath: accepts HI/LO-class ops, latches
// their operands, pulses md_start, counts the op latency and then pulses
// md_commit. While an op is in flight, any HI/LO-class instruction in E is
// stalled. mthi/mtlo are turned into one-cycle HI/LO write strobes, and a
// flush cancels an in-flight op with a one-cycle md_abort pulse.
//
// Optional feature: define MD_DIV0_FAST_EN to finish div/divu by zero in a
// single busy cycle with no start/commit pulse (HI/LO left unchanged).
//
// Handshake: there is no backpressure from the datapath. An E-stage op is
// taken in the cycle it is presented if e_valid_i & !busy_o & !flush_i;
// otherwise a HI/LO-class op is held in E by stall_o until the unit frees.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   e_valid_i        E-stage instruction valid
//   e_op_i[3:0]      0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,
//                    7 MFHI,8 MFLO,9 MADD,10 MADDU,11 MSUB,12 MSUBU,13-15 NONE
//   e_rs_i, e_rt_i   E-stage operand values
//   flush_i          kill E-stage instruction and any in-flight op
//   stall_o          freeze F/D/E (combinational)
//   busy_o           unit occupied
//   md_start_o       one-cycle start pulse to the datapath
//   md_op_o          latched op, held from start through commit/abort
//   md_a_o, md_b_o   latched rs/rt
//   md_commit_o      one-cycle pulse: result written into HI/LO
//   md_abort_o       one-cycle pulse: in-flight op cancelled
//   we_hi_o, we_lo_o one-cycle HI/LO write strobes for mthi/mtlo
//   wdata_o          data for we_hi_o/we_lo_o
//   dbg_state_o      current controller state (debug)

module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid_i,
    input  logic [3:0]  e_op_i,
    input  logic [31:0] e_rs_i,
    input  logic [31:0] e_rt_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        md_start_o,
    output logic [3:0]  md_op_o,
    output logic [31:0] md_a_o,
    output logic [31:0] md_b_o,
    output logic        md_commit_o,
    output logic        md_abort_o,
    output logic        we_hi_o,
    output logic        we_lo_o,
    output logic [31:0] wdata_o,
    output logic [1:0]  dbg_state_o
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Counter load values: the first RUN cycle already counts as one.
    localparam logic [CNT_W-1:0] MULT_CNT0 = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT0  = CNT_W'(DIV_LAT - 1);

    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DIV0 = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               md_start_q;
    logic [3:0]         md_op_q;
    logic [31:0]        md_a_q;
    logic [31:0]        md_b_q;
    logic               md_abort_q;
    logic               we_hi_q;
    logic               we_lo_q;
    logic [31:0]        wdata_q;

    // Instruction class decode
    logic is_div;
    logic is_arith;
    logic is_move;
    logic is_read;
    logic is_md;
    logic div0_fast;

    assign is_div   = (e_op_i == OP_DIV) || (e_op_i == OP_DIVU);
    assign is_arith = ((e_op_i >= 4'd1) && (e_op_i <= 4'd4)) ||
                      ((e_op_i >= 4'd9) && (e_op_i <= 4'd12));
    assign is_move  = (e_op_i == OP_MTHI) || (e_op_i == OP_MTLO);
    assign is_read  = (e_op_i == OP_MFHI) || (e_op_i == OP_MFLO);
    assign is_md    = is_arith | is_move | is_read;

`ifdef MD_DIV0_FAST_EN
    assign div0_fast = is_div && (e_rt_i == 32'd0);
`else
    assign div0_fast = 1'b0;
`endif

    logic busy;
    logic take;

    assign busy = (state_q != ST_IDLE);
    // Anything taken from E requires a free unit and no flush this cycle.
    assign take = e_valid_i & ~busy & ~flush_i;

    // Single FSM block: state, latency counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            md_start_q <= 1'b0;
            md_op_q    <= '0;
            md_a_q     <= '0;
            md_b_q     <= '0;
            md_abort_q <= 1'b0;
            we_hi_q    <= 1'b0;
            we_lo_q    <= 1'b0;
            wdata_q    <= '0;
        end else begin
            md_start_q <= 1'b0;
            md_abort_q <= 1'b0;
            we_hi_q    <= 1'b0;
            we_lo_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take && is_arith) begin
                        md_op_q <= e_op_i;
                        md_a_q  <= e_rs_i;
                        md_b_q  <= e_rt_i;
                        if (div0_fast) begin
                            state_q <= ST_DIV0;
                            cnt_q   <= '0;
                        end else begin
                            state_q    <= ST_RUN;
                            md_start_q <= 1'b1;
                            cnt_q      <= is_div ? DIV_CNT0 : MULT_CNT0;
                        end
                    end
                    if (take && is_move) begin
                        we_hi_q <= (e_op_i == OP_MTHI);
                        we_lo_q <= (e_op_i == OP_MTLO);
                        wdata_q <= e_rs_i;
                    end
                end
                ST_RUN: begin
                    // The commit cycle wins over a simultaneous flush.
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else if (flush_i) begin
                        state_q    <= ST_IDLE;
                        md_abort_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DIV0: begin
                    // One busy cycle, HI/LO untouched, nothing to abort.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_o     = e_valid_i & is_md & busy & ~flush_i;
    assign busy_o      = busy;
    assign md_start_o  = md_start_q;
    assign md_op_o     = md_op_q;
    assign md_a_o      = md_a_q;
    assign md_b_o      = md_b_q;
    // Commit is a pure function of registered state: last RUN cycle.
    assign md_commit_o = (state_q == ST_RUN) && (cnt_q == '0);
    assign md_abort_o  = md_abort_q;
    assign we_hi_o     = we_hi_q;
    assign we_lo_o     = we_lo_q;
    assign wdata_o     = wdata_q;
    assign dbg_state_o = state_q;

endmodule
